// File: rtl/pipe_rr_sched_if.sv
// rtl/pipe_rr_sched_if.sv - request, datapath and response bundle for pipe_rr_sched
// PIPE_RR_SCHED_STATS_EN adds o_grant_cnt
interface pipe_rr_sched_if #(
  parameter int N_REQ  = 4,
  parameter int W_DATA = 32
);
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_REQ*W_DATA-1:0] i_req_data;
  logic                    o_dp_valid;
  logic                    i_dp_ready;
  logic [W_DATA-1:0]       o_dp_data;
  logic                    i_dp_rsp_valid;
  logic [W_DATA-1:0]       i_dp_rsp_data;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [W_DATA-1:0]       o_rsp_data;
  logic                    i_flush;
  logic                    o_idle;
  logic                    o_err;
`ifdef PIPE_RR_SCHED_STATS_EN
  logic [N_REQ*16-1:0]     o_grant_cnt;
`endif

  modport slave (
    input  i_req_valid, i_req_data, i_dp_ready, i_dp_rsp_valid, i_dp_rsp_data, i_flush,
    output o_req_ready, o_dp_valid, o_dp_data, o_rsp_valid, o_rsp_data, o_idle, o_err
`ifdef PIPE_RR_SCHED_STATS_EN
    , output o_grant_cnt
`endif
  );

  modport master (
    output i_req_valid, i_req_data, i_dp_ready, i_dp_rsp_valid, i_dp_rsp_data, i_flush,
    input  o_req_ready, o_dp_valid, o_dp_data, o_rsp_valid, o_rsp_data, o_idle, o_err
`ifdef PIPE_RR_SCHED_STATS_EN
    , input o_grant_cnt
`endif
  );
endinterface

// File: rtl/pipe_rr_sched.sv
// rtl/pipe_rr_sched.sv - round-robin scheduler sharing one in-order pipelined datapath
// PIPE_RR_SCHED_STATS_EN adds saturating per-requester grant counters on o_grant_cnt
module pipe_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int W_DATA    = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic           i_clk,
  input  logic           resetn,
  pipe_rr_sched_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TAG_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]     rr_ptr, gnt_idx, cand, dp_tag;
  logic              gnt_found, grant_en, xfer, push, pop;
  logic [N_REQ-1:0]  req_ready;
  logic [W_DATA-1:0] gnt_data;
  logic [IW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       tag_cnt;
  int                scan_idx;

  assign push = bus.o_dp_valid & bus.i_dp_ready;
  assign pop  = bus.i_dp_rsp_valid & (tag_cnt != '0);

  // The issue register counts as occupied even while being accepted, so the FIFO can never overflow.
  assign grant_en = resetn && (state == RUN) && (!bus.o_dp_valid || bus.i_dp_ready) &&
                    ((tag_cnt + {{AW{1'b0}}, bus.o_dp_valid}) < DEPTH_C);
  assign xfer            = grant_en && gnt_found;
  assign req_ready       = xfer ? (N_REQ'(1) << gnt_idx) : '0;
  assign bus.o_req_ready = req_ready;
  assign bus.o_idle      = !bus.o_dp_valid && (tag_cnt == '0);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      cand = IW'(scan_idx);
      if (!gnt_found && bus.i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IW'(k)) gnt_data = bus.i_req_data[k*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (bus.i_flush) state_nxt = DRAIN;
      DRAIN:   if (!bus.i_flush && !bus.o_dp_valid && tag_cnt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state          <= RUN;
      rr_ptr         <= '0;
      bus.o_dp_valid <= 1'b0;
      bus.o_dp_data  <= '0;
      dp_tag         <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        bus.o_dp_valid <= 1'b1;
        bus.o_dp_data  <= gnt_data;
        dp_tag         <= gnt_idx;
        rr_ptr         <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (bus.i_dp_ready) begin
        bus.o_dp_valid <= 1'b0;
      end
    end
  end

  // Tag FIFO records issue order; results return in the same order.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < TAG_DEPTH; d++) tag_mem[d] <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_cnt         <= '0;
      bus.o_rsp_valid <= '0;
      bus.o_rsp_data  <= '0;
      bus.o_err       <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= dp_tag;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      bus.o_rsp_valid <= '0;
      if (bus.i_dp_rsp_valid) begin
        if (tag_cnt != '0) begin
          bus.o_rsp_valid <= N_REQ'(1) << tag_mem[rd_ptr];
          bus.o_rsp_data  <= bus.i_dp_rsp_data;
        end else begin
          bus.o_err <= 1'b1;
        end
      end
    end
  end

`ifdef PIPE_RR_SCHED_STATS_EN
  logic [15:0] grant_cnt [N_REQ];

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < N_REQ; k++) grant_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_ready[k] && bus.i_req_valid[k] && grant_cnt[k] != 16'hFFFF)
          grant_cnt[k] <= grant_cnt[k] + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
    assign bus.o_grant_cnt[k*16 +: 16] = grant_cnt[k];
  end
`endif
endmodule

// File: tb/tb_pipe_rr_sched.sv
// tb/tb_pipe_rr_sched.sv - scoreboard bench for pipe_rr_sched
module tb_pipe_rr_sched;
  localparam int N = 4;
  localparam int W = 32;
  localparam logic [31:0] KEY = 32'h5A5A_5A5A;

  typedef struct { int due; logic [31:0] data; } dp_t;
  typedef struct { int k; logic [3:0] oh; logic [31:0] data; } exp_t;

  logic i_clk;
  logic resetn;
  pipe_rr_sched_if #(.N_REQ(N), .W_DATA(W)) bus ();

  pipe_rr_sched #(.N_REQ(N), .W_DATA(W), .TAG_DEPTH(8)) dut (
    .i_clk (i_clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   dp_auto = 1'b1;
  int   force_req = 0;
  int   force_done = 0;
  int   rr_model = 0;
  int   grants_seen = 0;
  int   rsp_total = 0;
  int   rsp_seen [N];
  int   mk, mc;
  dp_t  pipe_q [$];
  exp_t exp_q [$];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [31:0] op_of(input int k, input int tagv);
    return {8'(k + 1), 8'(tagv), 16'hC0DE ^ 16'(tagv * 37)};
  endfunction

  task automatic set_req(input logic [3:0] v, input int tagv);
    bus.i_req_valid = v;
    for (int k = 0; k < N; k++) bus.i_req_data[k*W +: W] = op_of(k, tagv);
  endtask

  // Datapath model plus scoreboard monitor: inputs change on negedge, sampling 3 ns later.
  initial begin
    dp_t  h;
    exp_t e;
    for (int k = 0; k < N; k++) rsp_seen[k] = 0;
    bus.i_dp_rsp_valid = 1'b0;
    bus.i_dp_rsp_data  = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      bus.i_dp_rsp_valid = 1'b0;
      if (force_req > force_done) begin
        force_done++;
        bus.i_dp_rsp_valid = 1'b1;
        if (pipe_q.size() > 0) begin
          h = pipe_q.pop_front();
          bus.i_dp_rsp_data = h.data ^ KEY;
        end else begin
          bus.i_dp_rsp_data = 32'hDEAD_BEEF;
        end
      end else if (dp_auto && pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
        h = pipe_q.pop_front();
        bus.i_dp_rsp_valid = 1'b1;
        bus.i_dp_rsp_data  = h.data ^ KEY;
      end
      #3;
      if (!resetn) begin
        pipe_q.delete();
        exp_q.delete();
        rr_model = 0;
      end else begin
        if (bus.o_dp_valid && bus.i_dp_ready) begin
          h.due = cyc + 3;
          h.data = bus.o_dp_data;
          pipe_q.push_back(h);
        end
        if (bus.o_req_ready != '0) begin
          mk = -1;
          for (int i = 0; i < N; i++) begin
            mc = (rr_model + i) % N;
            if (mk < 0 && bus.i_req_valid[mc]) mk = mc;
          end
          checks++;
          if (mk < 0 || bus.o_req_ready !== 4'(1 << mk)) begin
            errors++;
            $display("FAIL grant_order got %b expected requester %0d (valid %b)", bus.o_req_ready, mk, bus.i_req_valid);
          end
          if (mk >= 0) begin
            e.k = mk;
            e.oh = 4'(1 << mk);
            e.data = bus.i_req_data[mk*W +: W] ^ KEY;
            exp_q.push_back(e);
            rr_model = (mk + 1) % N;
            grants_seen++;
          end
        end
        if (bus.o_rsp_valid != '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected got oh=%b data=%h expected no response", bus.o_rsp_valid, bus.o_rsp_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_rsp_valid !== e.oh || bus.o_rsp_data !== e.data) begin
              errors++;
              $display("FAIL rsp_route got oh=%b data=%h expected oh=%b data=%h", bus.o_rsp_valid, bus.o_rsp_data, e.oh, e.data);
            end else begin
              rsp_seen[e.k]++;
              rsp_total++;
            end
          end
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && bus.o_idle) && n < 60) begin
      @(negedge i_clk); #4;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !bus.o_idle) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d idle=%b expected pending=0 idle=1", nm, exp_q.size(), bus.o_idle);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_req(4'hF, 1);
    bus.i_dp_ready = 1'b1;
    bus.i_flush = 1'b0;
    repeat (2) @(negedge i_clk);
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b expected 0000", bus.o_req_ready);
    end
    checks++;
    if ({bus.o_dp_valid, bus.o_rsp_valid, bus.o_err, bus.o_idle} !== 7'b0_0000_01) begin
      errors++; $display("FAIL reset_flags got dpv=%b rspv=%b err=%b idle=%b expected 0 0000 0 1", bus.o_dp_valid, bus.o_rsp_valid, bus.o_err, bus.o_idle);
    end
    checks++;
    if (bus.o_dp_data !== 32'h0 || bus.o_rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got dp=%h rsp=%h expected 0 0", bus.o_dp_data, bus.o_rsp_data);
    end
    @(negedge i_clk);
    resetn = 1'b1;
    set_req(4'h0, 0);
  endtask

  task automatic test_rr_all();
    int g0;
    int s0 [N];
    g0 = grants_seen;
    for (int k = 0; k < N; k++) s0[k] = rsp_seen[k];
    for (int c = 0; c < 16; c++) begin
      @(negedge i_clk);
      set_req(4'hF, c);
      #4;
      if (c < 2) begin
        checks++;
        if (bus.o_req_ready !== 4'(1 << c)) begin
          errors++; $display("FAIL rr_first_grants cycle %0d got %b expected %b", c, bus.o_req_ready, 4'(1 << c));
        end
      end
    end
    @(negedge i_clk);
    set_req(4'h0, 0);
    #4;
    drain("rr_all");
    checks++;
    if (grants_seen - g0 != 16) begin
      errors++; $display("FAIL rr_grant_count got %0d expected 16", grants_seen - g0);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (rsp_seen[k] - s0[k] != 4) begin
        errors++; $display("FAIL rr_rsp_count req %0d got %0d expected 4", k, rsp_seen[k] - s0[k]);
      end
    end
  endtask

  task automatic test_single();
    @(negedge i_clk);
    bus.i_req_valid = 4'b0100;
    bus.i_req_data[2*W +: W] = 32'h11;
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant0 got %b expected 0100", bus.o_req_ready);
    end
    @(negedge i_clk);
    bus.i_req_data[2*W +: W] = 32'h22;
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0100 || bus.o_dp_valid !== 1'b1 || bus.o_dp_data !== 32'h11) begin
      errors++; $display("FAIL single_issue0 got rdy=%b dpv=%b dp=%h expected 0100 1 00000011", bus.o_req_ready, bus.o_dp_valid, bus.o_dp_data);
    end
    @(negedge i_clk);
    bus.i_req_valid = 4'b0000;
    #4;
    checks++;
    if (bus.o_dp_valid !== 1'b1 || bus.o_dp_data !== 32'h22) begin
      errors++; $display("FAIL single_issue1 got dpv=%b dp=%h expected 1 00000022", bus.o_dp_valid, bus.o_dp_data);
    end
    drain("single");
  endtask

  task automatic test_stall();
    @(negedge i_clk);
    bus.i_dp_ready = 1'b0;
    set_req(4'b0011, 7);
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0001) begin
      errors++; $display("FAIL stall_grant got %b expected 0001", bus.o_req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk); #4;
      checks++;
      if (bus.o_req_ready !== 4'b0000 || bus.o_dp_valid !== 1'b1 || bus.o_dp_data !== op_of(0, 7)) begin
        errors++; $display("FAIL stall_hold cycle %0d got rdy=%b dpv=%b dp=%h expected 0000 1 %h", i, bus.o_req_ready, bus.o_dp_valid, bus.o_dp_data, op_of(0, 7));
      end
    end
    @(negedge i_clk);
    bus.i_dp_ready = 1'b1;
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0010) begin
      errors++; $display("FAIL stall_release got %b expected 0010", bus.o_req_ready);
    end
    @(negedge i_clk);
    set_req(4'h0, 0);
    #4;
    drain("stall");
  endtask

  task automatic test_capacity();
    int g0;
    dp_auto = 1'b0;
    g0 = grants_seen;
    for (int c = 0; c < 14; c++) begin
      @(negedge i_clk);
      set_req(4'hF, 40 + c);
      #4;
    end
    checks++;
    if (grants_seen - g0 != 8) begin
      errors++; $display("FAIL cap_limit got %0d grants expected 8", grants_seen - g0);
    end
    force_req++;
    @(negedge i_clk); #4;
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin
      errors++; $display("FAIL cap_full got %b expected 0000", bus.o_req_ready);
    end
    @(negedge i_clk); #4;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      errors++; $display("FAIL cap_freed got %b expected 0100", bus.o_req_ready);
    end
    dp_auto = 1'b1;
    @(negedge i_clk);
    set_req(4'h0, 0);
    #4;
    drain("capacity");
  endtask

  task automatic test_flush();
    int r0;
    int n;
    r0 = rsp_total;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      set_req(4'hF, 60 + c);
      #4;
    end
    @(negedge i_clk);
    bus.i_flush = 1'b1;
    set_req(4'h0, 0);
    #4;
    n = 0;
    while (!bus.o_idle && n < 30) begin
      @(negedge i_clk);
      set_req(4'hF, 70);
      #4;
      n++;
      checks++;
      if (bus.o_req_ready !== 4'b0000) begin
        errors++; $display("FAIL flush_no_grant got %b expected 0000", bus.o_req_ready);
      end
    end
    checks++;
    if (!bus.o_idle || rsp_total - r0 != 3) begin
      errors++; $display("FAIL flush_idle got idle=%b routed=%0d expected 1 3", bus.o_idle, rsp_total - r0);
    end
    @(negedge i_clk);
    bus.i_flush = 1'b0;
    #4;
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin
      errors++; $display("FAIL flush_exit_cycle got %b expected 0000", bus.o_req_ready);
    end
    @(negedge i_clk); #4;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      errors++; $display("FAIL flush_resume got %b expected 0100", bus.o_req_ready);
    end
    @(negedge i_clk);
    set_req(4'h0, 0);
    #4;
    drain("flush");
  endtask

  task automatic test_err();
    @(negedge i_clk);
    resetn = 1'b0;
    @(negedge i_clk);
    resetn = 1'b1;
    #4;
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_idle !== 1'b1) begin
      errors++; $display("FAIL err_pre got err=%b idle=%b expected 0 1", bus.o_err, bus.o_idle);
    end
    force_req++;
    @(negedge i_clk); #4;
    @(negedge i_clk); #4;
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL err_set got err=%b rspv=%b expected 1 0000", bus.o_err, bus.o_rsp_valid);
    end
    repeat (3) @(negedge i_clk);
    #4;
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b expected 1", bus.o_err);
    end
    @(negedge i_clk);
    resetn = 1'b0;
    #4;
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b expected 0", bus.o_err);
    end
    @(negedge i_clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_single();
    test_stall();
    test_capacity();
    test_flush();
    test_err();
    repeat (2) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
